// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART-to-memory-bus debug initiator.
package uart_bus_pkg;

    // Frame command bytes
    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

    // Default reply bytes
    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEFAULT = 8'h15;

    // Control states
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP,
        NAK
    } ubm_state_e;

    // Byte idx of a little-endian word
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ubm_timer.sv
// Loadable up-counter with clear, enable and terminal-count compare.
// The count saturates at the limit so tc_o stays asserted until cleared.
module ubm_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear beats load beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/uart_bus_master.sv
// UART byte-stream to picorv32-style memory bus initiator.
// Decodes 'W'/'R' frames, issues one word transaction, replies with ACK,
// the read word (LSB first) or NAK.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = 1000000,
    parameter int unsigned BUS_TIMEOUT   = 255,
    parameter logic [7:0]  ACK_BYTE      = ACK_BYTE_DEFAULT,
    parameter logic [7:0]  NAK_BYTE      = NAK_BYTE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    // The frame timer fires after FRAME_TIMEOUT idle cycles. The bus timer is
    // cleared on BUS entry, so comparing against BUS_TIMEOUT-1 keeps
    // mem_valid_o high for exactly BUS_TIMEOUT cycles when no ready arrives.
    localparam logic [31:0] FRAME_LIMIT = 32'(FRAME_TIMEOUT);
    localparam logic [31:0] BUS_LIMIT   = 32'(BUS_TIMEOUT - 1);

    ubm_state_e  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        frame_clr;
    logic        frame_tc;
    logic        bus_clr;
    logic        bus_tc;

    // Inter-byte timer only runs while a frame is being collected
    assign frame_clr = rx_valid_i || !((state_q == ADDR) || (state_q == DATA));
    assign bus_clr   = (state_q != BUS);

    ubm_timer #(
        .WIDTH (32)
    ) u_frame_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (frame_clr),
        .en_i       (1'b1),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .limit_i    (FRAME_LIMIT),
        .tc_o       (frame_tc)
    );

    ubm_timer #(
        .WIDTH (32)
    ) u_bus_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (bus_clr),
        .en_i       (1'b1),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .limit_i    (BUS_LIMIT),
        .tc_o       (bus_tc)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_valid_d = mem_valid_q;
        mem_wstrb_d = mem_wstrb_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        unique case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    byte_cnt_d = 2'd0;
                    if (rx_data_i == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = ADDR;
                    end else if (rx_data_i == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = ADDR;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = NAK_BYTE;
                        state_d    = NAK;
                    end
                end
            end

            ADDR: begin
                if (rx_valid_i) begin
                    addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = DATA;
                        end else begin
                            mem_valid_d = 1'b1;
                            mem_wstrb_d = 4'h0;
                            state_d     = BUS;
                        end
                    end
                end else if (frame_tc) begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                if (rx_valid_i) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_valid_d = 1'b1;
                        mem_wstrb_d = 4'hF;
                        state_d     = BUS;
                    end
                end else if (frame_tc) begin
                    state_d = IDLE;
                end
            end

            BUS: begin
                // Ready wins over a simultaneous timeout
                if (mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'h0;
                    tx_valid_d  = 1'b1;
                    byte_cnt_d  = 2'd0;
                    state_d     = RESP;
                    if (is_write_q) begin
                        tx_data_d = ACK_BYTE;
                    end else begin
                        rdata_d   = mem_rdata_i;
                        tx_data_d = mem_rdata_i[7:0];
                    end
                end else if (bus_tc) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'h0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = NAK_BYTE;
                    state_d     = NAK;
                end
            end

            RESP: begin
                if (tx_ready_i) begin
                    if (is_write_q || (byte_cnt_q == 2'd3)) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = word_byte(rdata_q, byte_cnt_q + 2'd1);
                    end
                end
            end

            NAK: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                mem_valid_d = 1'b0;
                tx_valid_d  = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= 4'h0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_wstrb_q <= mem_wstrb_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign busy_o      = (state_q != IDLE);

endmodule
